// File: rtl/timer_pulse_gen.sv
// Single-cycle strobe generator for the LED sequencer: a free-running divider in run mode,
// or one pulse per debounced button press in step mode.
`timescale 1ns/1ps
module timer_pulse_gen #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DIV0       = 100_000_000,
  parameter int unsigned DIV1       = 50_000_000,
  parameter int unsigned DIV2       = 25_000_000,
  parameter int unsigned DIV3       = 12_500_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic [1:0] rate_sel,
  input  logic       step_btn,
  output logic       timer_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_last;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dcnt;
  logic             s1, s2;
  logic             deb;
  logic             mode_d;
  logic             deb_rise;
  logic             mode_chg;

  always_comb begin
    div = CNT_W'(DIV0);
    unique case (rate_sel)
      2'd0: div = CNT_W'(DIV0);
      2'd1: div = CNT_W'(DIV1);
      2'd2: div = CNT_W'(DIV2);
      2'd3: div = CNT_W'(DIV3);
      default: div = CNT_W'(DIV0);
    endcase
  end

  assign div_last = div - CNT_W'(1);
  // deb is about to be accepted high on this edge
  assign deb_rise = s2 & ~deb & (dcnt == DEB_LAST);
  assign mode_chg = (mode != mode_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      deb  <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= step_btn;
      s2 <= s1;
      if (s2 == deb) begin
        dcnt <= '0;
      end else if (dcnt == DEB_LAST) begin
        deb  <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      mode_d      <= 1'b0;
      timer_pulse <= 1'b0;
    end else begin
      mode_d <= mode;
      if (mode_chg) begin
        cnt         <= '0;
        timer_pulse <= 1'b0;
      end else if (!mode) begin
        if (!en) begin
          timer_pulse <= 1'b0;
        end else if (cnt >= div_last) begin
          // >= so a switch to a shorter period wraps on the next edge
          cnt         <= '0;
          timer_pulse <= 1'b1;
        end else begin
          cnt         <= cnt + CNT_W'(1);
          timer_pulse <= 1'b0;
        end
      end else begin
        cnt         <= '0;
        timer_pulse <= deb_rise & en;
      end
    end
  end

endmodule

// File: tb/tb_timer_pulse_gen.sv
// Scoreboard bench for timer_pulse_gen: stimulus queues the edge numbers at which a pulse
// is expected; the monitor matches every observed pulse against that queue.
`timescale 1ns/1ps
module tb_timer_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       step_btn = 1'b0;
  logic       timer_pulse;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int unsigned exp_q[$];
  int unsigned t;

  timer_pulse_gen #(
    .CNT_W(32), .DIV0(5), .DIV1(3), .DIV2(8), .DIV3(2), .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rate_sel(rate_sel),
    .step_btn(step_btn), .timer_pulse(timer_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after an edge; leaves rst released #1 after a later edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pulse", 32'(timer_pulse), 0);
    check("rst_cnt", dut.cnt, 0);
    check("rst_deb", 32'(dut.deb), 0);
    check("rst_mode_d", 32'(dut.mode_d), 0);
    wait_to(cyc + 2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check("missed_pulse", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (timer_pulse) begin
        if (exp_q.size() == 0) check("unexpected_pulse", cyc, 0);
        else check("pulse_edge", cyc, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: run mode, DIV0=5
    en = 1'b1; mode = 1'b0; rate_sel = 2'd0;
    wait_to(2);
    do_reset();
    t = cyc;
    exp_q.push_back(t + 5); exp_q.push_back(t + 10); exp_q.push_back(t + 15);
    wait_to(t + 17);

    // 2: rate switch below current count, then to the shortest period
    rate_sel = 2'd2;
    do_reset();
    t = cyc;
    wait_to(t + 6);
    check("cnt_reach6", dut.cnt, 6);
    rate_sel = 2'd1;
    exp_q.push_back(t + 7); exp_q.push_back(t + 10); exp_q.push_back(t + 13);
    wait_to(t + 13);
    rate_sel = 2'd3;
    exp_q.push_back(t + 15); exp_q.push_back(t + 17); exp_q.push_back(t + 19);
    wait_to(t + 19);
    rate_sel = 2'd0;

    // 3: pause at cnt=2 for 7 cycles
    wait_to(t + 21);
    check("cnt_before_pause", dut.cnt, 2);
    en = 1'b0;
    wait_to(t + 28);
    check("cnt_held", dut.cnt, 2);
    en = 1'b1;
    exp_q.push_back(t + 31);
    wait_to(t + 32);

    // 4: step mode, clean press, release, short glitch
    mode = 1'b1;
    wait_to(t + 33);
    check("cnt_after_mode_chg", dut.cnt, 0);
    t = cyc + 1;
    wait_to(t);
    step_btn = 1'b1;
    exp_q.push_back(t + 6);
    wait_to(t + 10);
    step_btn = 1'b0;
    wait_to(t + 20);
    check("deb_released", 32'(dut.deb), 0);
    step_btn = 1'b1;
    wait_to(t + 23);
    step_btn = 1'b0;
    wait_to(t + 35);
    check("deb_glitch_rejected", 32'(dut.deb), 0);

    // 5: bouncing press then stable high
    t = cyc;
    step_btn = 1'b1; wait_to(t + 2);
    step_btn = 1'b0; wait_to(t + 4);
    step_btn = 1'b1; wait_to(t + 6);
    step_btn = 1'b0; wait_to(t + 8);
    step_btn = 1'b1;
    exp_q.push_back(t + 14);
    wait_to(t + 20);
    check("deb_bounce_high", 32'(dut.deb), 1);
    step_btn = 1'b0;
    wait_to(t + 30);

    // 6: reset mid-period, then mode toggle on a terminal edge
    mode = 1'b0;
    t = cyc;
    wait_to(t + 4);
    check("cnt_before_rst", dut.cnt, 3);
    do_reset();
    t = cyc;
    wait_to(t + 4);
    check("cnt_at_terminal", dut.cnt, 4);
    mode = 1'b1;
    wait_to(t + 5);
    check("cnt_cleared_by_toggle", dut.cnt, 0);
    mode = 1'b0;
    exp_q.push_back(t + 11);
    wait_to(t + 13);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
